dds_sweep_ctrl: RTL and testbench

- Frequency-sweep scheduler that sequences the frequency control word (FCW) and phase offset fed into the dds_sram datapath.
- Sweeps FCW linearly from a start value to a stop value, in fixed increments, holding each frequency for a programmable dwell time.
- Gates all progress on the DDS ready flag (writed_), so no sweep step is issued while the sine table is loading or the phase accumulator is held in reset.
- Sits between the configuration registers and the dds_sram fcw/offset inputs.

---
 rtl/dds_sweep_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency-sweep scheduler driving the dds_sram fcw/offset inputs.
// Steps the FCW from a start value to a stop value in saturating increments, holding
// each frequency for a dwell of contiguous DDS-ready cycles. All progress waits on
// dds_ready so no step is issued while the sine table loads or the accumulator is held.
// Optional feature: define SWEEP_TRIANGLE_EN to add cfg_triangle (up-and-back sweep).
module dds_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        cfg_start_fcw,
  input  logic [31:0]        cfg_stop_fcw,
  input  logic [31:0]        cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [31:0]        cfg_offset,
  input  logic               cfg_continuous,
`ifdef SWEEP_TRIANGLE_EN
  input  logic               cfg_triangle,
`endif
  input  logic               dds_ready,
  output logic [31:0]        fcw,
  output logic [31:0]        offset,
  output logic               busy,
  output logic               done,
  output logic               step_stb
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_RDY = 2'd1;
  localparam logic [1:0] S_DWELL    = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  // Control / output registers (reset)
  logic [1:0]  state_q, state_d;
  logic [31:0] fcw_q, fcw_d;
  logic [31:0] offset_q, offset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        stb_q, stb_d;

  // Sweep shadow registers, latched at start (not reset)
  logic [31:0]        start_sh_q, start_sh_d;
  logic [31:0]        stop_sh_q, stop_sh_d;
  logic [31:0]        step_sh_q, step_sh_d;
  logic [DWELL_W-1:0] dwell_sh_q, dwell_sh_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               cont_q, cont_d;
  logic               down_q, down_d;   // current leg moves toward smaller FCW values
  logic               leg_q, leg_d;     // 0 = outbound toward stop, 1 = return toward start
  logic               triangle;

`ifdef SWEEP_TRIANGLE_EN
  logic triangle_q, triangle_d;
  assign triangle = triangle_q;
`else
  assign triangle = 1'b0;
`endif

  // One saturating step from cur toward tgt; the target is never overshot or wrapped past.
  function automatic logic [31:0] step_toward(input logic [31:0] cur, input logic [31:0] tgt,
                                              input logic [31:0] stp, input logic dn);
    logic [32:0] sum;
    logic [32:0] diff;
    sum  = {1'b0, cur} + {1'b0, stp};
    diff = {1'b0, cur} - {1'b0, stp};
    if (stp == '0)
      return tgt;
    else if (!dn)
      return (sum[32] || (sum[31:0] >= tgt)) ? tgt : sum[31:0];
    else
      return (diff[32] || (diff[31:0] <= tgt)) ? tgt : diff[31:0];
  endfunction

  logic [31:0]        target;
  logic [31:0]        other_end;
  logic [31:0]        next_fwd;
  logic [31:0]        next_turn;
  logic [DWELL_W-1:0] reload;

  // End-of-dwell candidates: next step on this leg, or first step after a triangle turn.
  always_comb begin
    target    = leg_q ? start_sh_q : stop_sh_q;
    other_end = leg_q ? stop_sh_q : start_sh_q;
    next_fwd  = step_toward(fcw_q, target, step_sh_q, down_q);
    next_turn = step_toward(fcw_q, other_end, step_sh_q, ~down_q);
    reload    = (dwell_sh_q == '0) ? '0 : dwell_sh_q - DWELL_W'(1);
  end

  // Next-state logic for the sweep sequencer.
  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path infers a latch.
    state_d    = state_q;
    fcw_d      = fcw_q;
    offset_d   = offset_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    stb_d      = 1'b0;
    start_sh_d = start_sh_q;
    stop_sh_d  = stop_sh_q;
    step_sh_d  = step_sh_q;
    dwell_sh_d = dwell_sh_q;
    cnt_d      = cnt_q;
    cont_d     = cont_q;
    down_d     = down_q;
    leg_d      = leg_q;
`ifdef SWEEP_TRIANGLE_EN
    triangle_d = triangle_q;
`endif
    case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous abort; abort means nothing while idle
        if (start) begin
          start_sh_d = cfg_start_fcw;
          stop_sh_d  = cfg_stop_fcw;
          step_sh_d  = cfg_step;
          dwell_sh_d = cfg_dwell;
          cont_d     = cfg_continuous;
          down_d     = cfg_start_fcw > cfg_stop_fcw;
          leg_d      = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
          triangle_d = cfg_triangle;
`endif
          fcw_d      = cfg_start_fcw;
          offset_d   = cfg_offset;
          busy_d     = 1'b1;
          state_d    = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (dds_ready) begin
          cnt_d   = reload;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!dds_ready) begin
          // counter reloads on resume, so each dwell is contiguous ready cycles
          state_d = S_WAIT_RDY;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          cnt_d = reload;
          if (fcw_q != target) begin
            fcw_d = next_fwd;
            stb_d = 1'b1;
          end else if (triangle && (!leg_q || cont_q)) begin
            // turn around: the end value was just dwelt once, step straight off it
            fcw_d  = next_turn;
            stb_d  = 1'b1;
            leg_d  = ~leg_q;
            down_d = ~down_q;
          end else if (cont_q) begin
            fcw_d = start_sh_q;
            stb_d = 1'b1;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with synchronous active-high reset.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= S_IDLE;
      fcw_q    <= '0;
      offset_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcw_q    <= fcw_d;
      offset_q <= offset_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      stb_q    <= stb_d;
    end
  end

  // Sweep shadow registers; always written at start before any use.
  always_ff @(posedge sys_clk) begin
    // NOTE: no reset here on purpose; IDLE never reads these and start loads them all.
    start_sh_q <= start_sh_d;
    stop_sh_q  <= stop_sh_d;
    step_sh_q  <= step_sh_d;
    dwell_sh_q <= dwell_sh_d;
    cnt_q      <= cnt_d;
    cont_q     <= cont_d;
    down_q     <= down_d;
    leg_q      <= leg_d;
`ifdef SWEEP_TRIANGLE_EN
    triangle_q <= triangle_d;
`endif
  end

  assign fcw      = fcw_q;
  assign offset   = offset_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_stb = stb_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed scenarios plus randomized sweeps,
// checked every cycle against a reference model that precomputes the FCW path
// arithmetically and tracks dwell as runs of contiguous ready cycles.
module tb_dds_sweep_ctrl;
  localparam int DWELL_W = 16;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic               reset, start, abort, cfg_continuous, dds_ready;
  logic [31:0]        cfg_start_fcw, cfg_stop_fcw, cfg_step, cfg_offset;
  logic [DWELL_W-1:0] cfg_dwell;
`ifdef SWEEP_TRIANGLE_EN
  logic               cfg_triangle;
`endif
  logic [31:0]        fcw, offset;
  logic               busy, done, step_stb;

  dds_sweep_ctrl #(.DWELL_W(DWELL_W)) dut (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_start_fcw  (cfg_start_fcw),
    .cfg_stop_fcw   (cfg_stop_fcw),
    .cfg_step       (cfg_step),
    .cfg_dwell      (cfg_dwell),
    .cfg_offset     (cfg_offset),
    .cfg_continuous (cfg_continuous),
`ifdef SWEEP_TRIANGLE_EN
    .cfg_triangle   (cfg_triangle),
`endif
    .dds_ready      (dds_ready),
    .fcw            (fcw),
    .offset         (offset),
    .busy           (busy),
    .done           (done),
    .step_stb       (step_stb)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  longint      seq[$];       // every FCW value the sweep visits, in order
  int          restart_idx;  // where a continuous sweep resumes after the last entry
  int          idx, run, m_dwell;
  bit          m_busy, m_done, m_stb, m_cont, armed;
  logic [31:0] m_fcw, m_offset;
  int          stb_seen, done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic longint toward(input longint v, input longint tgt, input longint st);
    if (st == 0) return tgt;
    if (tgt >= v) return (v + st >= tgt) ? tgt : v + st;
    return (v - st <= tgt) ? tgt : v - st;
  endfunction

  function automatic void build_seq(input logic [31:0] s, input logic [31:0] e,
                                    input logic [31:0] st, input bit tr);
    longint v, ls, le, lst;
    ls = longint'({32'b0, s});
    le = longint'({32'b0, e});
    lst = longint'({32'b0, st});
    seq.delete();
    v = ls;
    seq.push_back(v);
    while (v != le) begin
      v = toward(v, le, lst);
      seq.push_back(v);
    end
    if (tr) begin
      do begin
        v = toward(v, ls, lst);
        seq.push_back(v);
      end while (v != ls);
    end
    restart_idx = tr ? 1 : 0;
  endfunction

  // One clock: capture the inputs seen at the edge, advance the model, compare outputs.
  task automatic tick();
    bit r, s, a, rd, cc, tr, pd;
    logic [31:0] cs, ce, cst, co;
    logic [DWELL_W-1:0] cd;
    r = reset; s = start; a = abort; rd = dds_ready; cc = cfg_continuous;
    cs = cfg_start_fcw; ce = cfg_stop_fcw; cst = cfg_step; co = cfg_offset; cd = cfg_dwell;
    tr = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
    tr = cfg_triangle;
`endif
    @(posedge sys_clk);
    #1;
    pd = m_done;
    m_done = 0;
    m_stb = 0;
    if (r) begin
      m_busy = 0; m_fcw = '0; m_offset = '0;
    end else if (!m_busy) begin
      if (s && !pd) begin
        build_seq(cs, ce, cst, tr);
        idx = 0; run = 0; armed = 0;
        m_fcw = cs; m_offset = co; m_busy = 1;
        m_dwell = (cd == 0) ? 1 : int'(cd);
        m_cont = cc;
      end
    end else if (a) begin
      m_busy = 0;
    end else if (!rd) begin
      armed = 0;
    end else if (!armed) begin
      armed = 1; run = 0;
    end else begin
      run++;
      if (run >= m_dwell) begin
        run = 0;
        if (idx < seq.size() - 1) begin
          idx++; m_fcw = 32'(seq[idx]); m_stb = 1;
        end else if (m_cont) begin
          idx = restart_idx; m_fcw = 32'(seq[idx]); m_stb = 1;
        end else begin
          m_busy = 0; m_done = 1;
        end
      end
    end
    check("fcw", fcw, m_fcw);
    check("offset", offset, m_offset);
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("step_stb", 32'(step_stb), 32'(m_stb));
    stb_seen  += int'(step_stb);
    done_seen += int'(done);
  endtask

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                         input int dw, input logic [31:0] off, input bit cont);
    cfg_start_fcw = s; cfg_stop_fcw = e; cfg_step = st;
    cfg_dwell = DWELL_W'(dw); cfg_offset = off; cfg_continuous = cont;
  endtask

  task automatic go();
    stb_seen = 0; done_seen = 0;
    start = 1; tick(); start = 0;
  endtask

  task automatic run_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin tick(); n++; end
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic settle();
    tick(); tick();
  endtask

  initial begin
    int n;
    reset = 1; start = 0; abort = 0; dds_ready = 1;
    set_cfg(0, 0, 0, 0, 0, 0);
`ifdef SWEEP_TRIANGLE_EN
    cfg_triangle = 0;
`endif
    m_busy = 0; m_done = 0; m_stb = 0; m_fcw = '0; m_offset = '0;
    idx = 0; run = 0; armed = 0; m_dwell = 1; m_cont = 0; restart_idx = 0;
    tick(); tick();
    reset = 0;
    tick();
    check("reset_fcw", fcw, 32'd0);

    // Basic up sweep 100..130 step 10, dwell 3
    set_cfg(100, 130, 10, 3, 32'h1234_5678, 0);
    go(); run_idle(100);
    check("basic_stb_count", 32'(stb_seen), 32'd3);
    check("basic_done_count", 32'(done_seen), 32'd1);
    check("basic_final_fcw", fcw, 32'd130);
    settle();

    // Down sweep with clamp and a 5-cycle ready drop during the 0x30 dwell
    set_cfg(32'h50, 32'h08, 32'h20, 2, 32'h0000_ABCD, 0);
    go();
    n = 0;
    while (fcw !== 32'h30 && n < 40) begin tick(); n++; end
    check("down_reach_30", fcw, 32'h30);
    tick();
    dds_ready = 0;
    repeat (5) tick();
    check("down_hold_30", fcw, 32'h30);
    dds_ready = 1;
    run_idle(60);
    check("down_final_fcw", fcw, 32'h08);
    check("down_stb_count", 32'(stb_seen), 32'd3);
    settle();

    // Wrap guard near the top of the range
    set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 0, 0);
    go(); run_idle(40);
    check("wrap_final_fcw", fcw, 32'hFFFF_FFFF);
    check("wrap_stb_count", 32'(stb_seen), 32'd1);
    settle();

    // Continuous 0..40 step 20, then abort while fcw is 20
    set_cfg(0, 40, 20, 1, 32'h0000_0777, 1);
    go();
    repeat (12) tick();
    n = 0;
    while (fcw !== 32'd20 && n < 20) begin tick(); n++; end
    abort = 1; tick(); abort = 0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_fcw_hold", fcw, 32'd20);
    check("cont_no_done", 32'(done_seen), 32'd0);
    settle();

    // Zero step jumps straight to stop
    set_cfg(5, 500, 0, 2, 0, 0);
    go(); run_idle(40);
    check("step0_stb_count", 32'(stb_seen), 32'd1);
    check("step0_final_fcw", fcw, 32'd500);
    settle();

    // start and abort together in IDLE: sweep starts
    set_cfg(10, 20, 5, 1, 32'h0000_0042, 0);
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    check("start_beats_abort", 32'(busy), 32'd1);
    run_idle(40);
    settle();

    // Continuous with start==stop: reload each dwell, step_stb still pulses
    set_cfg(77, 77, 3, 2, 0, 1);
    go();
    repeat (10) tick();
    check("same_cont_stb_count", 32'(stb_seen), 32'd4);
    abort = 1; tick(); abort = 0;
    settle();

    // Reset asserted for 2 cycles mid-sweep
    set_cfg(1000, 2000, 1, 1, 32'h0000_0055, 0);
    go();
    repeat (10) tick();
    reset = 1; tick(); tick(); reset = 0;
    check("midreset_fcw", fcw, 32'd0);
    check("midreset_offset", offset, 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    tick();

`ifdef SWEEP_TRIANGLE_EN
    // Triangle 0..30..0 step 10 single-shot
    set_cfg(0, 30, 10, 1, 0, 0);
    cfg_triangle = 1;
    go(); run_idle(100);
    check("tri_stb_count", 32'(stb_seen), 32'd6);
    check("tri_done_count", 32'(done_seen), 32'd1);
    check("tri_final_fcw", fcw, 32'd0);
    cfg_triangle = 0;
    settle();
`endif

    // Randomized sweeps: ready gating, cfg churn, stray starts, occasional aborts
    for (int it = 0; it < 30; it++) begin
      logic [31:0] a, st;
      longint lb;
      a = (it % 4 == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255)) : 32'($urandom);
      lb = longint'({32'b0, a});
      if ($urandom_range(0, 1) == 1) lb = lb + longint'($urandom_range(0, 300));
      else lb = lb - longint'($urandom_range(0, 300));
      if (lb < 0) lb = 0;
      if (lb > 64'hFFFF_FFFF) lb = 64'hFFFF_FFFF;
      case ($urandom_range(0, 3))
        0:       st = 32'd0;
        1:       st = 32'($urandom);
        default: st = 32'($urandom_range(1, 60));
      endcase
      set_cfg(a, 32'(lb), st, int'($urandom_range(0, 3)), 32'($urandom),
              $urandom_range(0, 3) == 0);
`ifdef SWEEP_TRIANGLE_EN
      cfg_triangle = ($urandom_range(0, 1) == 1);
`endif
      go();
      for (int c = 0; c < 400 && busy; c++) begin
        dds_ready = ($urandom_range(0, 7) != 0);
        cfg_start_fcw = 32'($urandom);
        cfg_stop_fcw = 32'($urandom);
        cfg_step = 32'($urandom);
        cfg_offset = 32'($urandom);
        start = ($urandom_range(0, 19) == 0);
        abort = ($urandom_range(0, 199) == 0);
        tick();
        start = 0; abort = 0;
      end
      if (busy) begin abort = 1; tick(); abort = 0; end
      dds_ready = 1;
      settle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
